trap_sequencer: RTL and testbench
=================================

// Module: trap_sequencer
// PURPOSE
//  Multi-cycle trap-entry and MRET sequencer for the RV32I pipeline core. Sits after
//  instruction decode (XB stage). Consumes the decoder's exception flags and MRET request,
//  stalls and flushes the pipeline, and writes mepc/mcause/mtval one per cycle through the
//  single CSR write port. Then redirects fetch to mtvec (trap) or mepc (MRET).
// PARAMETERS
//  CSR_MEPC    12'h341  CSR address written with faulting PC
//  CSR_MCAUSE  12'h342  CSR address written with cause code
//  CSR_MTVAL   12'h343  CSR address written with trap value
// PORTS
//  clk          in   1   core clock; all state on rising edge
//  resetb       in   1   asynchronous, active-low reset
//  valid        in   1   XB-stage instruction valid
//  exc_unsup    in   1   decoder exception_unsupported_category
//  exc_illegal  in   1   decoder exception_illegal_instruction
//  exc_ld_mis   in   1   decoder exception_load_misaligned
//  exc_st_mis   in   1   decoder exception_store_misaligned
//  mret         in   1   decoder pc_update & pc_mepc
//  pc           in   32  PC of XB instruction
//  inst         in   32  XB instruction word
//  addr         in   32  effective data address of XB load/store
//  mtvec        in   32  current mtvec CSR value
//  mepc         in   32  current mepc CSR value
//  stall        out  1   hold IF/ID/XB registers
//  flush        out  1   squash XB instruction (kill regwrite/dm_we) and younger stages
//  csr_we       out  1   CSR write strobe
//  csr_addr     out  12  CSR write address
//  csr_wdata    out  32  CSR write data
//  status_push  out  1   1-cycle pulse: mstatus MPIE<=MIE, MIE<=0
//  status_pop   out  1   1-cycle pulse: mstatus MIE<=MPIE, MPIE<=1
//  pc_load      out  1   load fetch PC with pc_target
//  pc_target    out  32  redirect target
// BEHAVIOUR
//  - Reset: state=IDLE, all registered outputs 0, latched pc/cause/tval 0. A reset mid-trap
//    abandons the sequence; no further CSR writes are issued.
//  - trap = valid & (exc_unsup|exc_illegal|exc_ld_mis|exc_st_mis). Sampled only in IDLE.
//  - Cause priority: unsup/illegal -> 2; ld_mis -> 4; st_mis -> 6. tval = inst for cause 2,
//    addr for causes 4/6.
//  - States: IDLE, W_EPC, W_CAUSE, W_TVAL, REDIR.
//  - Trap entry:
//    cycle0 IDLE: trap seen; combinational stall=1, flush=1; latch pc/cause/tval; ->W_EPC.
//    cycle1 W_EPC: csr_we=1, addr=CSR_MEPC, data=pc; ->W_CAUSE.
//    cycle2 W_CAUSE: csr_we=1, addr=CSR_MCAUSE, data={ecbit,27'b0,cause}; ->W_TVAL.
//    cycle3 W_TVAL: csr_we=1, addr=CSR_MTVAL, data=tval, status_push=1; ->REDIR.
//    cycle4 REDIR: pc_load=1, pc_target={mtvec[31:2],2'b00}, flush=1; ->IDLE.
//  - MRET (valid & mret & ~trap in IDLE): stall=1 for that cycle; ->REDIR next cycle with
//    pc_target={mepc[31:2],2'b00}, status_pop=1, pc_load=1, flush=1. No CSR writes.
//  - stall=1 in every non-IDLE state. All inputs are ignored outside IDLE.
//  - Simultaneous trap and mret: trap wins. Multiple exception flags: priority above.
//  - csr_we is never asserted in IDLE or REDIR. pc_load is asserted only in REDIR.
// CONFIGURATION
//  TRAP_SEQ_IRQ_EN defined:
//  - Adds ports irq (in 1, level machine external interrupt) and mie (in 1, mstatus.MIE).
//  - In IDLE, valid & irq & mie & ~trap takes an interrupt. mepc <= pc (XB instruction not
//    executed, flushed), cause=11, ecbit=1, tval=0. Same 5-state sequence as a trap.
//  - A synchronous trap has priority over the interrupt in the same cycle. MRET has
//    priority over irq.
//  TRAP_SEQ_IRQ_EN undefined: no irq/mie ports, and ecbit is always 0.
// STRUCTURE
//  - core/trap.vh: cause codes (2, 4, 6, 11), default CSR addresses, state encodings.
//  - Sub-module trap_cause_encoder: combinational priority encoder from flags to
//    {cause[3:0], tval_sel}. The FSM, latches and CSR mux live in trap_sequencer.
// TESTING
//  - Illegal inst=32'h0000_0000 at pc=32'h100, mtvec=32'h200: csr writes 341<-100,
//    342<-2, 343<-0 on cycles 1-3; pc_load with target 200 at cycle 4; stall high
//    cycles 0-4.
//  - LW with addr=32'h1002 at pc=32'h40: mcause=4, mtval=32'h1002. ld_mis+illegal
//    together: mcause=2.
//  - MRET with mepc=32'h104: no csr_we; status_pop and pc_load target 104 one cycle after
//    mret; back in IDLE next cycle.
//  - Deassert resetb during W_CAUSE: outputs 0 immediately; no 343 write; after release,
//    a new trap runs the full sequence.
//  - Exception pulses arriving in W_EPC..REDIR: ignored; exactly 3 CSR writes per trap.
//  - IRQ_EN: irq=1, mie=1, add at pc=32'h80: mcause=32'h8000_000B, mepc=32'h80. irq with
//    mie=0: no action.

Source files
------------

// File: rtl/trap_sequencer_pkg.sv
// trap_sequencer_pkg: shared types and constants for the trap-entry / MRET sequencer.
//   - state_e     : sequencer FSM states
//   - tval_sel_e  : source of the mtval value (instruction word or data address)
//   - cause codes : mcause exception codes used by the sequencer
//   - CSR address defaults for mepc / mcause / mtval
//   - align4()    : clears the two LSBs of a redirect target
package trap_sequencer_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StWEpc,
        StWCause,
        StWTval,
        StRedir
    } state_e;

    typedef enum logic {
        TvalInst,
        TvalAddr
    } tval_sel_e;

    localparam logic [3:0] CauseIllegal  = 4'd2;
    localparam logic [3:0] CauseLdMis    = 4'd4;
    localparam logic [3:0] CauseStMis    = 4'd6;
    localparam logic [3:0] CauseMExtIrq  = 4'd11;

    localparam logic [11:0] CsrMepcDefault   = 12'h341;
    localparam logic [11:0] CsrMcauseDefault = 12'h342;
    localparam logic [11:0] CsrMtvalDefault  = 12'h343;

    function automatic logic [31:0] align4(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/trap_sequencer_if.sv
// trap_sequencer_if: XB-stage side-band bundle between the pipeline and the trap sequencer.
//   Pipeline -> sequencer : valid, exc_unsup, exc_illegal, exc_ld_mis, exc_st_mis, mret,
//                           pc, inst, addr, mtvec, mepc (+ irq, mie with TRAP_SEQ_IRQ_EN)
//   Sequencer -> pipeline : stall, flush, csr_we, csr_addr, csr_wdata,
//                           status_push, status_pop, pc_load, pc_target
//   modport master : pipeline side; modport slave : sequencer side.
//   Optional macro TRAP_SEQ_IRQ_EN adds the irq / mie inputs.
interface trap_sequencer_if;

`ifdef TRAP_SEQ_IRQ_EN
    logic        irq;
    logic        mie;
`endif
    logic        valid;
    logic        exc_unsup;
    logic        exc_illegal;
    logic        exc_ld_mis;
    logic        exc_st_mis;
    logic        mret;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] addr;
    logic [31:0] mtvec;
    logic [31:0] mepc;

    logic        stall;
    logic        flush;
    logic        csr_we;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic        status_push;
    logic        status_pop;
    logic        pc_load;
    logic [31:0] pc_target;

    modport master (
`ifdef TRAP_SEQ_IRQ_EN
        output irq, mie,
`endif
        output valid, exc_unsup, exc_illegal, exc_ld_mis, exc_st_mis, mret,
        output pc, inst, addr, mtvec, mepc,
        input  stall, flush, csr_we, csr_addr, csr_wdata,
        input  status_push, status_pop, pc_load, pc_target
    );

    modport slave (
`ifdef TRAP_SEQ_IRQ_EN
        input  irq, mie,
`endif
        input  valid, exc_unsup, exc_illegal, exc_ld_mis, exc_st_mis, mret,
        input  pc, inst, addr, mtvec, mepc,
        output stall, flush, csr_we, csr_addr, csr_wdata,
        output status_push, status_pop, pc_load, pc_target
    );

endinterface

// File: rtl/trap_sequencer_cause_encoder.sv
// trap_cause_encoder: combinational priority encoder from decoder exception flags to
// an mcause code and the mtval source select.
//   exc_unsup, exc_illegal, exc_ld_mis, exc_st_mis : decoder exception flags
//   cause    : 2 (unsupported/illegal) > 4 (load misaligned) > 6 (store misaligned)
//   tval_sel : TvalInst for cause 2, TvalAddr for causes 4/6
// Output is don't-care when no flag is set; the sequencer only samples it on a trap.
module trap_cause_encoder
    import trap_sequencer_pkg::*;
(
    input  logic       exc_unsup,
    input  logic       exc_illegal,
    input  logic       exc_ld_mis,
    input  logic       exc_st_mis,
    output logic [3:0] cause,
    output tval_sel_e  tval_sel
);

    always_comb begin
        cause    = CauseIllegal;
        tval_sel = TvalInst;
        if (exc_unsup || exc_illegal) begin
            cause    = CauseIllegal;
            tval_sel = TvalInst;
        end else if (exc_ld_mis) begin
            cause    = CauseLdMis;
            tval_sel = TvalAddr;
        end else if (exc_st_mis) begin
            cause    = CauseStMis;
            tval_sel = TvalAddr;
        end
    end

endmodule

// File: rtl/trap_sequencer.sv
// trap_sequencer: multi-cycle trap-entry and MRET sequencer for the RV32I core (XB stage).
//   clk    : core clock, rising edge
//   resetb : asynchronous active-low reset; abandons any sequence in flight
//   bus    : trap_sequencer_if.slave (decoder flags / PC / CSR values in; stall, flush,
//            CSR write port, mstatus push/pop pulses and fetch redirect out)
// A trap writes mepc, mcause, mtval on three consecutive cycles, then redirects to mtvec.
// MRET stalls one cycle, then redirects to mepc and pops mstatus. Redirect targets are
// captured in IDLE, so CSR inputs changing mid-sequence have no effect.
// Optional macro TRAP_SEQ_IRQ_EN adds a level machine external interrupt (cause 11, ecbit=1).
module trap_sequencer
    import trap_sequencer_pkg::*;
#(
    parameter logic [11:0] CSR_MEPC   = CsrMepcDefault,
    parameter logic [11:0] CSR_MCAUSE = CsrMcauseDefault,
    parameter logic [11:0] CSR_MTVAL  = CsrMtvalDefault
) (
    input  logic              clk,
    input  logic              resetb,
    trap_sequencer_if.slave   bus
);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [3:0]  cause_q, cause_d;
    logic        ecbit_q, ecbit_d;
    logic [31:0] tval_q, tval_d;
    logic [31:0] target_q, target_d;
    logic        mret_q, mret_d;

    logic [3:0]  enc_cause;
    tval_sel_e   enc_tval_sel;
    logic        trap, take_mret, take_irq, take_entry;

    trap_cause_encoder u_cause_enc (
        .exc_unsup   (bus.exc_unsup),
        .exc_illegal (bus.exc_illegal),
        .exc_ld_mis  (bus.exc_ld_mis),
        .exc_st_mis  (bus.exc_st_mis),
        .cause       (enc_cause),
        .tval_sel    (enc_tval_sel)
    );

    assign trap      = bus.valid &
                       (bus.exc_unsup | bus.exc_illegal | bus.exc_ld_mis | bus.exc_st_mis);
    assign take_mret = bus.valid & bus.mret & ~trap;
`ifdef TRAP_SEQ_IRQ_EN
    // Synchronous traps and MRET both outrank the interrupt.
    assign take_irq  = bus.valid & bus.irq & bus.mie & ~trap & ~take_mret;
`else
    assign take_irq  = 1'b0;
`endif
    assign take_entry = trap | take_irq;

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_q  <= StIdle;
            pc_q     <= '0;
            cause_q  <= '0;
            ecbit_q  <= 1'b0;
            tval_q   <= '0;
            target_q <= '0;
            mret_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            cause_q  <= cause_d;
            ecbit_q  <= ecbit_d;
            tval_q   <= tval_d;
            target_q <= target_d;
            mret_q   <= mret_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        cause_d         = cause_q;
        ecbit_d         = ecbit_q;
        tval_d          = tval_q;
        target_d        = target_q;
        mret_d          = mret_q;
        bus.stall       = 1'b0;
        bus.flush       = 1'b0;
        bus.csr_we      = 1'b0;
        bus.csr_addr    = '0;
        bus.csr_wdata   = '0;
        bus.status_push = 1'b0;
        bus.status_pop  = 1'b0;
        bus.pc_load     = 1'b0;
        bus.pc_target   = '0;

        case (state_q)
            StIdle: begin
                if (take_entry) begin
                    bus.stall = 1'b1;
                    bus.flush = 1'b1;
                    pc_d      = bus.pc;
                    ecbit_d   = take_irq;
                    cause_d   = take_irq ? CauseMExtIrq : enc_cause;
                    if (take_irq) begin
                        tval_d = '0;
                    end else begin
                        tval_d = (enc_tval_sel == TvalAddr) ? bus.addr : bus.inst;
                    end
                    target_d  = align4(bus.mtvec);
                    mret_d    = 1'b0;
                    state_d   = StWEpc;
                end else if (take_mret) begin
                    bus.stall = 1'b1;
                    target_d  = align4(bus.mepc);
                    mret_d    = 1'b1;
                    state_d   = StRedir;
                end
            end
            StWEpc: begin
                bus.stall     = 1'b1;
                bus.csr_we    = 1'b1;
                bus.csr_addr  = CSR_MEPC;
                bus.csr_wdata = pc_q;
                state_d       = StWCause;
            end
            StWCause: begin
                bus.stall     = 1'b1;
                bus.csr_we    = 1'b1;
                bus.csr_addr  = CSR_MCAUSE;
                bus.csr_wdata = {ecbit_q, 27'b0, cause_q};
                state_d       = StWTval;
            end
            StWTval: begin
                bus.stall       = 1'b1;
                bus.csr_we      = 1'b1;
                bus.csr_addr    = CSR_MTVAL;
                bus.csr_wdata   = tval_q;
                bus.status_push = 1'b1;
                state_d         = StRedir;
            end
            StRedir: begin
                bus.stall      = 1'b1;
                bus.flush      = 1'b1;
                bus.pc_load    = 1'b1;
                bus.pc_target  = target_q;
                bus.status_pop = mret_q;
                state_d        = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

endmodule

// File: tb/tb_trap_sequencer.sv
// tb_trap_sequencer: directed self-checking bench for trap_sequencer.
// Output vector layout: {stall, flush, csr_we, csr_addr, csr_wdata,
//                        status_push, status_pop, pc_load, pc_target}.
// Build with +define+TRAP_SEQ_IRQ_EN to include the interrupt scenarios.
module tb_trap_sequencer;

    typedef logic [81:0] ovec_t;

    typedef struct {
        logic [3:0]  exc;      // {unsup, illegal, ld_mis, st_mis}
        logic        m;
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] addr;
        logic [31:0] mtvec;
        logic [31:0] mcause;
        logic [31:0] tval;
        logic [31:0] tgt;
    } trap_case_t;

    logic clk = 1'b0;
    logic resetb = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    trap_sequencer_if bus ();

    trap_sequencer dut (
        .clk    (clk),
        .resetb (resetb),
        .bus    (bus)
    );

    function automatic ovec_t mk(input logic [2:0] sfw, input logic [11:0] a,
                                 input logic [31:0] d, input logic [2:0] ppl,
                                 input logic [31:0] t);
        return {sfw, a, d, ppl, t};
    endfunction

    function automatic ovec_t observed();
        return {bus.stall, bus.flush, bus.csr_we, bus.csr_addr, bus.csr_wdata,
                bus.status_push, bus.status_pop, bus.pc_load, bus.pc_target};
    endfunction

    // Expected outputs for cycle c of a trap entry (c=5 is the first IDLE cycle after).
    function automatic ovec_t trap_exp(input int c, input logic [31:0] pc,
                                       input logic [31:0] mc, input logic [31:0] tv,
                                       input logic [31:0] tgt);
        case (c)
            0:       return mk(3'b110, 12'h000, 32'h0, 3'b000, 32'h0);
            1:       return mk(3'b101, 12'h341, pc,    3'b000, 32'h0);
            2:       return mk(3'b101, 12'h342, mc,    3'b000, 32'h0);
            3:       return mk(3'b101, 12'h343, tv,    3'b100, 32'h0);
            4:       return mk(3'b110, 12'h000, 32'h0, 3'b001, tgt);
            default: return '0;
        endcase
    endfunction

    task automatic drive(input logic v, input logic [3:0] exc, input logic m,
                         input logic [31:0] pc, input logic [31:0] inst,
                         input logic [31:0] addr, input logic [31:0] mtvec,
                         input logic [31:0] mepc);
        bus.valid       = v;
        bus.exc_unsup   = exc[3];
        bus.exc_illegal = exc[2];
        bus.exc_ld_mis  = exc[1];
        bus.exc_st_mis  = exc[0];
        bus.mret        = m;
        bus.pc          = pc;
        bus.inst        = inst;
        bus.addr        = addr;
        bus.mtvec       = mtvec;
        bus.mepc        = mepc;
    endtask

    task automatic drive_idle();
        drive(1'b0, 4'b0000, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    endtask

    task automatic test_reset();
        ovec_t o;
        resetb = 1'b0;
        drive_idle();
        #1;
        o = observed();
        vectors++;
        if (o !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h expected %h", o, ovec_t'(0));
        end
        @(negedge clk);
        resetb = 1'b1;
        #1;
        o = observed();
        vectors++;
        if (o !== '0) begin
            miscompares++;
            $display("FAIL reset_release_idle: got %h expected %h", o, ovec_t'(0));
        end
    endtask

    task automatic test_trap_entry();
        trap_case_t tc[7];
        ovec_t o, e;
        tc[0] = '{4'b0100, 1'b0, 32'h100, 32'h0000_0000, 32'h0,    32'h200,
                  32'h2, 32'h0000_0000, 32'h200};
        tc[1] = '{4'b0010, 1'b0, 32'h040, 32'h0000_2003, 32'h1002, 32'h200,
                  32'h4, 32'h0000_1002, 32'h200};
        tc[2] = '{4'b0110, 1'b0, 32'h044, 32'hFFFF_FFFF, 32'h1006, 32'h203,
                  32'h2, 32'hFFFF_FFFF, 32'h200};
        tc[3] = '{4'b0001, 1'b0, 32'h048, 32'h0010_2123, 32'h2001, 32'h400,
                  32'h6, 32'h0000_2001, 32'h400};
        tc[4] = '{4'b0011, 1'b0, 32'h04C, 32'h0000_1234, 32'h3003, 32'h400,
                  32'h4, 32'h0000_3003, 32'h400};
        tc[5] = '{4'b1000, 1'b0, 32'h050, 32'h0000_007F, 32'h0010, 32'h401,
                  32'h2, 32'h0000_007F, 32'h400};
        tc[6] = '{4'b0100, 1'b1, 32'h054, 32'h0000_0000, 32'h0000, 32'h500,
                  32'h2, 32'h0000_0000, 32'h500};
        for (int i = 0; i < 7; i++) begin
            for (int c = 0; c < 6; c++) begin
                @(negedge clk);
                if (c == 0) begin
                    drive(1'b1, tc[i].exc, tc[i].m, tc[i].pc, tc[i].inst, tc[i].addr,
                          tc[i].mtvec, 32'h104);
                end else begin
                    drive_idle();
                end
                #1;
                o = observed();
                e = trap_exp(c, tc[i].pc, tc[i].mcause, tc[i].tval, tc[i].tgt);
                vectors++;
                if (o !== e) begin
                    miscompares++;
                    $display("FAIL trap_entry case%0d cyc%0d: got %h expected %h", i, c, o, e);
                end
            end
        end
    endtask

    task automatic test_mret();
        ovec_t o, e;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (c == 0) drive(1'b1, 4'b0000, 1'b1, 32'h60, 32'h3020_0073, 32'h0,
                              32'h200, 32'h106);
            else        drive_idle();
            #1;
            o = observed();
            case (c)
                0:       e = mk(3'b100, 12'h000, 32'h0, 3'b000, 32'h0);
                1:       e = mk(3'b110, 12'h000, 32'h0, 3'b011, 32'h104);
                default: e = '0;
            endcase
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL mret cyc%0d: got %h expected %h", c, o, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        ovec_t o, e;
        for (int c = 0; c < 11; c++) begin
            @(negedge clk);
            if (c == 0)      drive(1'b1, 4'b0100, 1'b0, 32'h100, 32'h0, 32'h0, 32'h200, 32'h0);
            else if (c == 5) drive(1'b1, 4'b0010, 1'b0, 32'h064, 32'h2003, 32'h0F01,
                                   32'h600, 32'h0);
            else             drive_idle();
            #1;
            o = observed();
            if (c < 5) e = trap_exp(c, 32'h100, 32'h2, 32'h0, 32'h200);
            else       e = trap_exp(c - 5, 32'h064, 32'h4, 32'h0F01, 32'h600);
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL back_to_back cyc%0d: got %h expected %h", c, o, e);
            end
        end
    endtask

    task automatic test_ignore_busy();
        ovec_t o, e;
        int we_count = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c == 0)      drive(1'b1, 4'b0100, 1'b0, 32'h100, 32'h0, 32'h0, 32'h200, 32'h0);
            else if (c < 5)  drive(1'b1, 4'b1111, 1'b1, 32'hDEAD_BEE0, 32'hFFFF_FFFF,
                                   32'h1235, 32'hFFF0, 32'hEEE0);
            else             drive_idle();
            #1;
            o = observed();
            if (bus.csr_we === 1'b1) we_count++;
            e = trap_exp(c, 32'h100, 32'h2, 32'h0, 32'h200);
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL ignore_busy cyc%0d: got %h expected %h", c, o, e);
            end
        end
        vectors++;
        if (we_count !== 3) begin
            miscompares++;
            $display("FAIL ignore_busy_we_count: got %0d expected 3", we_count);
        end
    endtask

    task automatic test_reset_mid();
        ovec_t o, e;
        int we_count = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (c == 0) drive(1'b1, 4'b0001, 1'b0, 32'h70, 32'h0, 32'h71, 32'h200, 32'h0);
            else        drive_idle();
            #1;
            o = observed();
            e = trap_exp(c, 32'h70, 32'h6, 32'h71, 32'h200);
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL reset_mid pre cyc%0d: got %h expected %h", c, o, e);
            end
        end
        #1 resetb = 1'b0;
        #1;
        o = observed();
        vectors++;
        if (o !== '0) begin
            miscompares++;
            $display("FAIL reset_mid immediate: got %h expected %h", o, ovec_t'(0));
        end
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            if (bus.csr_we === 1'b1) we_count++;
        end
        vectors++;
        if (we_count !== 0) begin
            miscompares++;
            $display("FAIL reset_mid writes_in_reset: got %0d expected 0", we_count);
        end
        @(negedge clk);
        resetb = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c == 0) drive(1'b1, 4'b0100, 1'b0, 32'h74, 32'h0000_FFFF, 32'h0, 32'h208, 32'h0);
            else        drive_idle();
            #1;
            o = observed();
            e = trap_exp(c, 32'h74, 32'h2, 32'h0000_FFFF, 32'h208);
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL reset_mid post cyc%0d: got %h expected %h", c, o, e);
            end
        end
    endtask

`ifdef TRAP_SEQ_IRQ_EN
    task automatic test_irq();
        ovec_t o, e;
        // Interrupt taken on an ADD at 0x80.
        bus.irq = 1'b1;
        bus.mie = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c == 0) drive(1'b1, 4'b0000, 1'b0, 32'h80, 32'h0000_0033, 32'h0, 32'h300, 32'h0);
            else        drive_idle();
            if (c == 4) bus.irq = 1'b0;
            #1;
            o = observed();
            e = trap_exp(c, 32'h80, 32'h8000_000B, 32'h0, 32'h300);
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL irq_taken cyc%0d: got %h expected %h", c, o, e);
            end
        end
        // Masked interrupt: nothing happens.
        bus.irq = 1'b1;
        bus.mie = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            drive(1'b1, 4'b0000, 1'b0, 32'h84, 32'h0000_0033, 32'h0, 32'h300, 32'h0);
            #1;
            o = observed();
            vectors++;
            if (o !== '0) begin
                miscompares++;
                $display("FAIL irq_masked cyc%0d: got %h expected %h", c, o, ovec_t'(0));
            end
        end
        // Synchronous trap beats the interrupt.
        bus.mie = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c == 0) drive(1'b1, 4'b0100, 1'b0, 32'h88, 32'h0000_0BAD, 32'h0, 32'h300, 32'h0);
            else        drive_idle();
            if (c == 4) bus.irq = 1'b0;
            #1;
            o = observed();
            e = trap_exp(c, 32'h88, 32'h2, 32'h0000_0BAD, 32'h300);
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL irq_vs_trap cyc%0d: got %h expected %h", c, o, e);
            end
        end
        // MRET beats the interrupt.
        bus.irq = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            if (c == 0) drive(1'b1, 4'b0000, 1'b1, 32'h8C, 32'h3020_0073, 32'h0, 32'h300, 32'h108);
            else        drive_idle();
            if (c == 1) bus.irq = 1'b0;
            #1;
            o = observed();
            if (c == 0) e = mk(3'b100, 12'h000, 32'h0, 3'b000, 32'h0);
            else        e = mk(3'b110, 12'h000, 32'h0, 3'b011, 32'h108);
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL irq_vs_mret cyc%0d: got %h expected %h", c, o, e);
            end
        end
        bus.irq = 1'b0;
        bus.mie = 1'b0;
    endtask
`endif

    initial begin
`ifdef TRAP_SEQ_IRQ_EN
        bus.irq = 1'b0;
        bus.mie = 1'b0;
`endif
        test_reset();
        test_trap_entry();
        test_mret();
        test_back_to_back();
        test_ignore_busy();
        test_reset_mid();
`ifdef TRAP_SEQ_IRQ_EN
        test_irq();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
